// File: rtl/muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter
// Iterative radix-2 multiply/divide unit for the EX stage. Handles signed and
// unsigned multiply, divide, and multiply-accumulate/subtract into a 2*WIDTH
// HI/LO accumulator. Every operation takes a fixed WIDTH+1 cycles from
// acceptance to result, and both sides use a valid/ready handshake.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : asynchronous active-low reset
//   flush      : synchronous cancel; forces IDLE and discards any result
//   opn_valid  : operand request
//   opn_ready  : unit can accept a request (IDLE only)
//   op         : 000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU (op[0] = unsigned)
//   a, b       : multiplicand/multiplier or dividend/divisor
//   hilo_in    : accumulator for MADD/MSUB
//   res_valid  : result available (DONE only)
//   res_ready  : consumer takes the result
//   result     : {hi, lo}; for divides hi = remainder, lo = quotient
//   busy       : operation in progress (BUSY or FIX)
// -----------------------------------------------------------------------------
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 opn_valid,
  output logic                 opn_ready,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2*WIDTH-1:0]   hilo_in,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  // Two's-complement negation helpers.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + ONE_2W;
  endfunction

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic [2*WIDTH-1:0]   hilo_q, hilo_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     mag_b_q, mag_b_d;
  logic                 neg_a_q, neg_a_d;
  logic                 neg_b_q, neg_b_d;
  // acc holds {partial product hi, multiplier lo} or {remainder, quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  // Operand conditioning at acceptance.
  logic               neg_a_in_s, neg_b_in_s;
  logic [WIDTH-1:0]   mag_a_in_s, mag_b_in_s;

  assign neg_a_in_s = ~op[0] & a[WIDTH-1];
  assign neg_b_in_s = ~op[0] & b[WIDTH-1];
  assign mag_a_in_s = neg_a_in_s ? neg_w(a) : a;
  assign mag_b_in_s = neg_b_in_s ? neg_w(b) : b;

  // Operation class decode of the captured op.
  logic op_div_s, op_madd_s, op_msub_s;

  assign op_div_s  = (op_q[2:1] == 2'b01);
  assign op_madd_s = (op_q[2:1] == 2'b10);
  assign op_msub_s = (op_q[2:1] == 2'b11);

  // Multiply step: conditionally add multiplicand into hi, then shift the
  // whole {carry, hi, lo} right by one.
  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   mul_step_s;

  assign mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_b_q};
  assign mul_step_s = acc_q[0] ? {mul_sum_s, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};

  // Restoring divide step: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits. The shifted remainder needs WIDTH+1
  // bits; after a successful subtract the low WIDTH bits are exact.
  logic [WIDTH:0]       div_rem_sh_s;
  logic                 div_ge_s;
  logic [WIDTH-1:0]     div_diff_s;
  logic [2*WIDTH-1:0]   div_step_s;

  assign div_rem_sh_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge_s     = (div_rem_sh_s >= {1'b0, mag_b_q});
  assign div_diff_s   = div_rem_sh_s[WIDTH-1:0] - mag_b_q;
  assign div_step_s   = div_ge_s
                        ? {div_diff_s, acc_q[WIDTH-2:0], 1'b1}
                        : {div_rem_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  // Sign fix-up of the unsigned magnitudes produced by the iterations.
  logic                 res_neg_s, rem_neg_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quot_s, rem_s;
  logic                 div_zero_s, div_ovf_s;
  logic [2*WIDTH-1:0]   fix_s;
  logic                 last_step_s;

  assign res_neg_s   = ~op_q[0] & (neg_a_q ^ neg_b_q);
  assign rem_neg_s   = ~op_q[0] & neg_a_q;
  assign prod_s      = res_neg_s ? neg_2w(acc_q) : acc_q;
  assign quot_s      = res_neg_s ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign rem_s       = rem_neg_s ? neg_w(acc_q[2*WIDTH-1:WIDTH])
                                 : acc_q[2*WIDTH-1:WIDTH];
  assign div_zero_s  = (mag_b_q == ZERO_W);
  assign div_ovf_s   = ~op_q[0] & (a_q == MIN_W) & neg_b_q & (mag_b_q == ONE_W);
  assign last_step_s = (cnt_q == CNT_LAST);

  // Final result formation for the FIX cycle.
  always_comb begin
    fix_s = prod_s;
    if (op_div_s) begin
      if (div_zero_s) begin
        fix_s = {a_q, ONES_W};
      end else if (div_ovf_s) begin
        fix_s = {ZERO_W, MIN_W};
      end else begin
        fix_s = {rem_s, quot_s};
      end
    end else if (op_madd_s) begin
      fix_s = hilo_q + prod_s;
    end else if (op_msub_s) begin
      fix_s = hilo_q - prod_s;
    end else begin
      fix_s = prod_s;
    end
  end

  // FSM next-state; flush overrides acceptance and the result handshake.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (opn_valid) begin
            state_d = S_BUSY;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_BUSY: begin
          if (last_step_s) begin
            state_d = S_FIX;
          end else begin
            state_d = S_BUSY;
          end
        end
        S_FIX: begin
          state_d = S_DONE;
        end
        S_DONE: begin
          if (res_ready) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Datapath next-state: capture, iterate, fix up.
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    hilo_d   = hilo_q;
    a_d      = a_q;
    mag_b_d  = mag_b_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (flush) begin
      cnt_d    = CNT_ZERO;
      result_d = ZERO_2W;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (opn_valid) begin
            op_d    = op;
            hilo_d  = hilo_in;
            a_d     = a;
            mag_b_d = mag_b_in_s;
            neg_a_d = neg_a_in_s;
            neg_b_d = neg_b_in_s;
            acc_d   = {ZERO_W, mag_a_in_s};
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d   = cnt_q;
          end
        end
        S_BUSY: begin
          acc_d = op_div_s ? div_step_s : mul_step_s;
          cnt_d = cnt_q + CNT_ONE;
        end
        S_FIX: begin
          result_d = fix_s;
        end
        S_DONE: begin
          result_d = result_q;
        end
        default: begin
          cnt_d = CNT_ZERO;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      op_q     <= 3'b000;
      hilo_q   <= ZERO_2W;
      a_q      <= ZERO_W;
      mag_b_q  <= ZERO_W;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      acc_q    <= ZERO_2W;
      result_q <= ZERO_2W;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      hilo_q   <= hilo_d;
      a_q      <= a_d;
      mag_b_q  <= mag_b_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign opn_ready = (state_q == S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_BUSY) || (state_q == S_FIX);
  assign result    = result_q;

endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Parametrised iterative multiply/divide unit for the EX stage. It generalises the fixed 32-bit signed/unsigned mult and div datapath to any operand width, and adds accumulate modes (MADD/MSUB) and a full valid/ready handshake on both operand and result. A flush input cancels an operation in flight. The pipeline stalls on `busy`, and the 2·WIDTH result feeds the HI/LO write path.

## Interface
- `WIDTH`, default 32: operand width; legal values are ≥ 4. The result is 2·WIDTH bits.
- `CNT_W`, default `$clog2(WIDTH+1)`: iteration counter width. Derived; do not override.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `flush`  in  1: synchronous cancel (exception or branch flush).
- `opn_valid`  in  1: operand request.
- `opn_ready`  out  1: unit can accept a request; high only in IDLE.
- `op`  in  3: operation. `000` MULT, `001` MULTU, `010` DIV, `011` DIVU, `100` MADD, `101` MADDU, `110` MSUB, `111` MSUBU. `op[0]` = unsigned.
- `a`  in  WIDTH: multiplicand or dividend.
- `b`  in  WIDTH: multiplier or divisor.
- `hilo_in`  in  2·WIDTH: accumulator for MADD/MSUB. Ignored for the other ops.
- `res_valid`  out  1: result available; high only in DONE.
- `res_ready`  in  1: consumer takes the result.
- `result`  out  2·WIDTH: `{hi, lo}`.
- `busy`  out  1: `state != IDLE && state != DONE`.

## Operation
- **States:** IDLE, BUSY, FIX, DONE.
- **IDLE:**
  - Acceptance happens when `opn_valid & ~flush`.
  - On acceptance, capture `op` and `hilo_in`.
  - Capture the magnitudes `|a|` and `|b|` (signed ops take the two's-complement absolute value).
  - Record the sign flags, clear the counter, go to BUSY.
- **BUSY:** one radix-2 step per cycle for exactly WIDTH cycles; the counter increments every step. After the step with counter = WIDTH−1, go to FIX.
  - Multiply: shift-add on the 2·WIDTH partial product.
  - Divide: restoring shift-subtract that produces the quotient and remainder magnitudes.
- **FIX:** one cycle that forms the final result, then go to DONE. Arithmetic:
  - MULT/MULTU: `{hi, lo}` = product (full 2·WIDTH, negated when the signs differ for MULT).
  - MADD(U): `hilo_in + product`, modulo 2^(2·WIDTH).
  - MSUB(U): `hilo_in − product`, modulo 2^(2·WIDTH).
  - DIV/DIVU: `hi` = remainder, `lo` = quotient. Signed division truncates toward zero; the remainder takes the dividend's sign.
  - Divide by zero, any sign: `hi = a` (as captured), `lo = all ones`.
  - Signed overflow, MIN / −1: `lo = MIN`, `hi = 0`.
- **DONE:** `res_valid = 1`; `result` is held stable until handshake. When `res_ready` is high, go to IDLE on the next edge.
- **flush:** in any state, the next edge forces IDLE and `res_valid` falls.
  - The result is discarded.
  - Flush beats acceptance and the result handshake in the same cycle.
- **Reset** (`rst` = 0, asynchronous, any state):
  - State returns to IDLE and the counter clears.
  - `opn_ready = 1`; `res_valid = 0`; `busy = 0`; `result = 0`.
  - Internal registers clear.

## Timing
- **Acceptance** occurs at edge E0 when `opn_ready & opn_valid & ~flush`.
- **Result latency:** iterations run on edges E1..E_WIDTH; FIX resolves on edge E_WIDTH+1. `res_valid` is high from E_WIDTH+1, i.e. WIDTH+1 cycles after acceptance (33 for WIDTH = 32). Latency is fixed for every op and operand, including divide by zero.
- **busy:** high for cycles E0+ through E_WIDTH+; low in DONE.
- **Result handshake:** if `res_ready` is high in the first DONE cycle, IDLE follows at E_WIDTH+2 and `opn_ready` rises then. The next op can be accepted at that same edge only through the IDLE cycle, so back-to-back spacing is WIDTH+3 edges.
- **Held result:** `res_valid` stays high with `res_ready` low for an unbounded number of cycles; `result` is unchanged throughout.
- **Input stability:** inputs `a`, `b`, `op` and `hilo_in` need only be stable in the acceptance cycle.
- **Outputs:** all outputs are registered or decoded from state; there is no combinational path from inputs to outputs.

## Test plan
- **MULT:** WIDTH=32, MULT `a = 0xFFFFFFFE` (−2), `b = 3` → after 33 cycles `result = 0xFFFFFFFF_FFFFFFFA`. MULTU with the same operands → `0x00000002_FFFFFFFA`.
- **DIV:** DIV `a = −7`, `b = 2` → `hi = 0xFFFFFFFF` (−1), `lo = 0xFFFFFFFD` (−3). DIVU `a = 7`, `b = 0` → `hi = 7`, `lo = 0xFFFFFFFF`. DIV `0x80000000 / 0xFFFFFFFF` → `hi = 0`, `lo = 0x80000000`.
- **MADD/MSUB:** MADD `hilo_in = 0x00000001_00000000`, `a = 0x10000`, `b = 0x10000` → `0x00000002_00000000`. MSUBU `hilo_in = 0`, `a = 1`, `b = 1` → `0xFFFFFFFF_FFFFFFFF`.
- **Back-pressure:** hold `res_ready = 0` for 10 cycles after `res_valid` → `result` is stable, `opn_ready = 0`. Then pulse `res_ready` → IDLE next edge; a new op is accepted one cycle later.
- **Flush and reset mid-operation:**
  - Assert `flush` on iteration 15 → IDLE next edge; no `res_valid` pulse.
  - A new request then completes with the correct value.
  - Drop `rst` mid-BUSY asynchronously → outputs reach reset values immediately.
- **Width sweep:** WIDTH = 8, MULT `0x80 × 0x80` → `0x4000`, `res_valid` at 9 cycles. WIDTH = 64: random signed and unsigned MUL/DIV/MADD/MSUB checked against a reference model, latency 65.
